// File: rtl/har_bnn_pkg.sv
// Shared constants, FSM state type and weight generator for the HAR BNN stream classifier.
package har_bnn_pkg;

    localparam int FEAT_CNT   = 12;
    localparam int FEAT_BITS  = 4;
    localparam int HIDDEN_CNT = 40;
    localparam int CLASS_CNT  = 6;
    localparam int CNT_W      = 16;
    localparam int PRED_W     = $clog2(CLASS_CNT);

    // Weight rows are generated 64 bits wide and sliced to the layer input width.
    localparam int ROW_W = 64;

    // Salts separate the hidden-layer weights from the output-layer weights.
    localparam int unsigned W1_SALT = 32'd0;
    localparam int unsigned W2_SALT = 32'd101;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_e;

    // One binary weight: multiplicative hash of (row, column, salt), bit 7 after folding.
    function automatic logic weight_bit(input int unsigned row, input int unsigned col,
                                        input int unsigned salt);
        logic [31:0] h;
        h = (row + salt + 32'd1) * (col + 32'd3) * 32'h9E37_79B1;
        h = h ^ (h >> 16);
        return h[7];
    endfunction

    // A full weight row; bit c weights input bit c of the layer.
    function automatic logic [ROW_W-1:0] weight_row(input int unsigned row, input int unsigned salt);
        logic [ROW_W-1:0] w;
        w = '0;
        for (int c = 0; c < ROW_W; c++) begin
            w[c] = weight_bit(row, c, salt);
        end
        return w;
    endfunction

endpackage

// File: rtl/Har_bnn1_bnnpaar.sv
// Combinational binary neural network: XNOR-popcount hidden layer with a
// half-width threshold, XNOR-popcount output scores, argmax (lowest index wins ties).
module Har_bnn1_bnnpaar #(
    parameter int FEAT_W     = har_bnn_pkg::FEAT_CNT * har_bnn_pkg::FEAT_BITS,
    parameter int HIDDEN_CNT = har_bnn_pkg::HIDDEN_CNT,
    parameter int CLASS_CNT  = har_bnn_pkg::CLASS_CNT,
    parameter int PRED_W     = $clog2(CLASS_CNT)
) (
    input  logic [FEAT_W-1:0] features,
    output logic [PRED_W-1:0] prediction
);
    import har_bnn_pkg::*;

    // Layer widths must fit inside one generated weight row (both are at most 64 here).
    localparam int ACC1_W = $clog2(FEAT_W + 1);
    localparam int ACC2_W = $clog2(HIDDEN_CNT + 1);

    logic [HIDDEN_CNT-1:0]         hidden;
    logic [CLASS_CNT*ACC2_W-1:0]   score_flat;
    logic [ACC2_W-1:0]             best_score;
    logic [PRED_W-1:0]             best_idx;

    for (genvar n = 0; n < HIDDEN_CNT; n++) begin : g_hidden
        localparam logic [ROW_W-1:0] W_ROW = weight_row(n, W1_SALT);
        logic [FEAT_W-1:0] agree;
        logic [ACC1_W-1:0] agree_cnt;

        assign agree = ~(features ^ W_ROW[FEAT_W-1:0]);

        // Popcount of feature bits that agree with this neuron's weights.
        always_comb begin
            // NOTE: assign the accumulator before the loop so every path drives it; otherwise a latch is inferred.
            agree_cnt = '0;
            for (int b = 0; b < FEAT_W; b++) begin
                agree_cnt = agree_cnt + ACC1_W'(agree[b]);
            end
        end

        assign hidden[n] = (agree_cnt >= ACC1_W'(FEAT_W / 2));
    end

    for (genvar c = 0; c < CLASS_CNT; c++) begin : g_class
        localparam logic [ROW_W-1:0] V_ROW = weight_row(c, W2_SALT);
        logic [HIDDEN_CNT-1:0] agree;
        logic [ACC2_W-1:0]     agree_cnt;

        assign agree = ~(hidden ^ V_ROW[HIDDEN_CNT-1:0]);

        // Popcount of hidden activations that agree with this class's weights.
        always_comb begin
            agree_cnt = '0;
            for (int j = 0; j < HIDDEN_CNT; j++) begin
                agree_cnt = agree_cnt + ACC2_W'(agree[j]);
            end
        end

        assign score_flat[c*ACC2_W +: ACC2_W] = agree_cnt;
    end

    // Argmax over class scores; a strictly greater score is needed to displace an earlier class.
    always_comb begin
        best_score = score_flat[ACC2_W-1:0];
        best_idx   = '0;
        for (int c = 1; c < CLASS_CNT; c++) begin
            if (score_flat[c*ACC2_W +: ACC2_W] > best_score) begin
                best_score = score_flat[c*ACC2_W +: ACC2_W];
                best_idx   = PRED_W'(c);
            end
        end
    end

    assign prediction = best_idx;

endmodule

// File: rtl/har_bnn1_stream_classifier.sv
// Stream front end for Har_bnn1_bnnpaar: collects features on a valid/ready
// input, classifies the packed vector in one cycle, and offers the class on a
// valid/ready result port with a framing-error flag and a consumed-result counter.
module har_bnn1_stream_classifier #(
    parameter int FEAT_CNT   = har_bnn_pkg::FEAT_CNT,
    parameter int FEAT_BITS  = har_bnn_pkg::FEAT_BITS,
    parameter int HIDDEN_CNT = har_bnn_pkg::HIDDEN_CNT,
    parameter int CLASS_CNT  = har_bnn_pkg::CLASS_CNT,
    parameter int CNT_W      = har_bnn_pkg::CNT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [FEAT_BITS-1:0]         s_data,
    input  logic                         s_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [$clog2(CLASS_CNT)-1:0] m_pred,
    output logic                         m_err,
    output logic [CNT_W-1:0]             result_cnt
);
    import har_bnn_pkg::*;

    localparam int PRED_BITS = $clog2(CLASS_CNT);
    localparam int VEC_W     = FEAT_CNT * FEAT_BITS;
    localparam int IDX_W     = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEAT_CNT - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [VEC_W-1:0]       feat_q, feat_d;
    logic                   err_q, err_d;
    logic [PRED_BITS-1:0]   pred_q, pred_d;
    logic [CNT_W-1:0]       result_cnt_q, result_cnt_d;

    logic [PRED_BITS-1:0]   bnn_pred;
    logic                   beat_fire;
    logic                   at_last_slot;
    int                     slot_lsb;

    Har_bnn1_bnnpaar #(
        .FEAT_W     (VEC_W),
        .HIDDEN_CNT (HIDDEN_CNT),
        .CLASS_CNT  (CLASS_CNT),
        .PRED_W     (PRED_BITS)
    ) u_bnn (
        .features   (feat_q),
        .prediction (bnn_pred)
    );

    assign s_ready      = (state_q == LOAD);
    assign m_valid      = (state_q == HOLD);
    assign m_pred       = pred_q;
    assign m_err        = err_q;
    assign result_cnt   = result_cnt_q;

    assign beat_fire    = s_valid & s_ready;
    assign at_last_slot = (idx_q == LAST_IDX);
    // Beat k lands in slot FEAT_CNT-1-k, so the first beat is the most significant nibble.
    assign slot_lsb     = (FEAT_CNT - 1 - int'(idx_q)) * FEAT_BITS;

    // Next-state logic: beat assembly, framing checks, evaluation and result handshake.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        feat_d       = feat_q;
        err_d        = err_q;
        pred_d       = pred_q;
        result_cnt_d = result_cnt_q;

        case (state_q)
            LOAD: begin
                if (beat_fire) begin
                    feat_d[slot_lsb +: FEAT_BITS] = s_data;
                    if (s_last || at_last_slot) begin
                        // Early last leaves the zero-filled tail; missing last still evaluates.
                        state_d = EVAL;
                        err_d   = ~(s_last & at_last_slot);
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            EVAL: begin
                pred_d  = bnn_pred;
                state_d = HOLD;
            end

            HOLD: begin
                if (m_ready) begin
                    result_cnt_d = result_cnt_q + 1'b1;
                    feat_d       = '0;
                    idx_d        = '0;
                    err_d        = 1'b0;
                    state_d      = LOAD;
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State registers; reset returns every register, including the vector, to zero at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: feat_q is a flop vector, not a RAM, so it is reset; the zero-fill for early-last frames depends on it.
            state_q      <= LOAD;
            idx_q        <= '0;
            feat_q       <= '0;
            err_q        <= 1'b0;
            pred_q       <= '0;
            result_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q      <= state_d;
            idx_q        <= idx_d;
            feat_q       <= feat_d;
            err_q        <= err_d;
            pred_q       <= pred_d;
            result_cnt_q <= result_cnt_d;
        end
    end

endmodule

// File: tb/tb_har_bnn1_stream_classifier.sv
// Scoreboard bench for har_bnn1_stream_classifier: the driver pushes the expected
// result of each framed vector; an independent monitor pops it on every result handshake.
module tb_har_bnn1_stream_classifier;
    import har_bnn_pkg::*;

    localparam int VEC_W   = FEAT_CNT * FEAT_BITS;
    localparam int TIMEOUT = 200;

    typedef struct {
        logic [VEC_W-1:0]  vec;
        logic [PRED_W-1:0] pred;
        logic              err;
    } exp_t;

    typedef logic [FEAT_BITS-1:0] nib_arr_t [FEAT_CNT];

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 s_valid;
    logic                 s_ready;
    logic [FEAT_BITS-1:0] s_data;
    logic                 s_last;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic [PRED_W-1:0]    m_pred;
    logic                 m_err;
    logic [CNT_W-1:0]     result_cnt;

    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;
    exp_t sb[$];

    bit   rand_ready  = 1'b0;
    logic ready_force = 1'b1;
    bit   gaps        = 1'b0;

    always #5 clk = ~clk;

    har_bnn1_stream_classifier dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_pred     (m_pred),
        .m_err      (m_err),
        .result_cnt (result_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference classifier written directly from the network definition.
    function automatic bit ref_weight(input int unsigned row, input int unsigned col,
                                      input int unsigned salt);
        int unsigned h;
        h = (row + salt + 1) * (col + 3) * 32'h9E3779B1;
        h = h ^ (h >> 16);
        return h[7];
    endfunction

    function automatic logic [PRED_W-1:0] ref_classify(input logic [VEC_W-1:0] v);
        bit hid [HIDDEN_CNT];
        int agree;
        int best;
        int best_c;
        for (int n = 0; n < HIDDEN_CNT; n++) begin
            agree = 0;
            for (int b = 0; b < VEC_W; b++) begin
                if (v[b] == ref_weight(n, b, 0)) agree++;
            end
            hid[n] = (2 * agree >= VEC_W);
        end
        best   = -1;
        best_c = 0;
        for (int c = 0; c < CLASS_CNT; c++) begin
            agree = 0;
            for (int j = 0; j < HIDDEN_CNT; j++) begin
                if (hid[j] == ref_weight(c, j, 101)) agree++;
            end
            if (agree > best) begin
                best   = agree;
                best_c = c;
            end
        end
        return PRED_W'(best_c);
    endfunction

    // m_ready driver: changes just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Result monitor: handshake checks against the scoreboard plus hold-stability rules.
    initial begin
        bit                hold_prev;
        logic [PRED_W-1:0] pred_prev;
        logic              err_prev;
        exp_t              e;
        hold_prev = 1'b0;
        pred_prev = '0;
        err_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                hold_prev = 1'b0;
            end else begin
                if (m_valid) check("s_ready_low_in_hold", s_ready, 0);
                if (hold_prev) begin
                    check("hold_valid_stable", m_valid, 1);
                    check("hold_pred_stable", m_pred, pred_prev);
                    check("hold_err_stable", m_err, err_prev);
                end
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got pred 0x%0h, want no result pending", m_pred);
                    end else begin
                        e = sb.pop_front();
                        check("result_pred", m_pred, e.pred);
                        check("result_err", m_err, e.err);
                        check("result_vector", dut.feat_q, e.vec);
                        check("result_cnt_before", result_cnt, exp_cnt);
                        exp_cnt++;
                    end
                end
                hold_prev = m_valid && !m_ready;
                pred_prev = m_pred;
                err_prev  = m_err;
            end
        end
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic send_beat(input logic [FEAT_BITS-1:0] d, input logic last);
        bit acc;
        acc = 1'b0;
        if (gaps) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        for (int t = 0; t < TIMEOUT && !acc; t++) begin
            acc = s_ready;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("beat_accepted", acc, 1);
    endtask

    task automatic send_vector(input nib_arr_t nib, input int n, input bit with_last,
                               input bit expect_result);
        logic [VEC_W-1:0] vec;
        exp_t             e;
        vec = '0;
        for (int k = 0; k < n; k++) begin
            vec = vec | (VEC_W'(nib[k]) << (FEAT_BITS * (FEAT_CNT - 1 - k)));
        end
        e.vec  = vec;
        e.err  = !(with_last && n == FEAT_CNT);
        e.pred = ref_classify(vec);
        for (int k = 0; k < n; k++) begin
            if (k == n - 1 && expect_result) sb.push_back(e);
            send_beat(nib[k], with_last && (k == n - 1));
        end
    endtask

    task automatic wait_valid(input string name);
        int t;
        t = 0;
        while (!m_valid && t < TIMEOUT) begin
            @(negedge clk);
            t++;
        end
        check(name, m_valid, 1);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((sb.size() != 0 || m_valid) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic assert_reset_now();
        #2 rst_n = 1'b0;
        sb.delete();
        exp_cnt = 0;
        #1;
    endtask

    task automatic release_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached with %0d results pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        nib_arr_t         nib;
        logic [PRED_W-1:0] pred_hold;
        int               t;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        release_reset();

        // Reset values
        check("reset_s_ready", s_ready, 1);
        check("reset_m_valid", m_valid, 0);
        check("reset_m_pred", m_pred, 0);
        check("reset_m_err", m_err, 0);
        check("reset_result_cnt", result_cnt, 0);
        check("reset_feat", dut.feat_q, 0);

        // Normal vector 1..C, consumer always ready, exact cycle timing
        for (int k = 0; k < FEAT_CNT; k++) nib[k] = FEAT_BITS'(k + 1);
        send_vector(nib, FEAT_CNT, 1'b1, 1'b1);
        check("normal_eval_s_ready", s_ready, 0);
        check("normal_eval_m_valid", m_valid, 0);
        @(negedge clk);
        check("normal_hold_m_valid", m_valid, 1);
        check("normal_feat", dut.feat_q, 48'h1234_5678_9ABC);
        check("normal_pred", m_pred, ref_classify(48'h1234_5678_9ABC));
        check("normal_err", m_err, 0);
        @(negedge clk);
        check("normal_valid_one_cycle", m_valid, 0);
        check("normal_ready_after_hs", s_ready, 1);
        check("normal_result_cnt", result_cnt, 1);

        // Back-pressure: hold m_ready low for 5 cycles of HOLD
        ready_force = 1'b0;
        for (int k = 0; k < FEAT_CNT; k++) nib[k] = FEAT_BITS'($urandom_range(0, 15));
        send_vector(nib, FEAT_CNT, 1'b1, 1'b1);
        wait_valid("bp_valid_seen");
        pred_hold = m_pred;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid_held", m_valid, 1);
            check("bp_s_ready_low", s_ready, 0);
            check("bp_pred_held", m_pred, pred_hold);
        end
        ready_force = 1'b1;
        t = 0;
        while (m_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("bp_handshake_latency", t, 2);
        check("bp_ready_after_hs", s_ready, 1);
        check("bp_result_cnt", result_cnt, 2);

        // Early last: A,B,C then zero-filled tail
        nib[0] = 4'hA;
        nib[1] = 4'hB;
        nib[2] = 4'hC;
        send_vector(nib, 3, 1'b1, 1'b1);
        wait_valid("early_valid_seen");
        check("early_feat", dut.feat_q, 48'hABC0_0000_0000);
        check("early_err", m_err, 1);
        check("early_pred", m_pred, ref_classify(48'hABC0_0000_0000));
        drain("early_drain");

        // Missing last: twelve F beats without s_last, then a normal vector
        for (int k = 0; k < FEAT_CNT; k++) nib[k] = 4'hF;
        send_vector(nib, FEAT_CNT, 1'b0, 1'b1);
        wait_valid("missing_valid_seen");
        check("missing_feat", dut.feat_q, 48'hFFFF_FFFF_FFFF);
        check("missing_err", m_err, 1);
        @(negedge clk);
        for (int k = 0; k < FEAT_CNT; k++) nib[k] = FEAT_BITS'(k + 1);
        send_vector(nib, FEAT_CNT, 1'b1, 1'b1);
        drain("missing_drain");
        check("missing_result_cnt", result_cnt, 5);

        // Reset after 5 beats: outputs clear asynchronously, no result
        for (int k = 0; k < FEAT_CNT; k++) nib[k] = FEAT_BITS'($urandom_range(0, 15));
        send_vector(nib, 5, 1'b0, 1'b0);
        assert_reset_now();
        check("midrst_s_ready", s_ready, 1);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_result_cnt", result_cnt, 0);
        check("midrst_m_pred", m_pred, 0);
        check("midrst_feat", dut.feat_q, 0);
        release_reset();
        for (int k = 0; k < FEAT_CNT; k++) nib[k] = FEAT_BITS'($urandom_range(0, 15));
        send_vector(nib, FEAT_CNT, 1'b1, 1'b1);
        drain("midrst_drain");
        check("midrst_next_cnt", result_cnt, 1);

        // Reset while a result is held
        ready_force = 1'b0;
        send_vector(nib, FEAT_CNT, 1'b1, 1'b1);
        wait_valid("holdrst_valid_seen");
        assert_reset_now();
        check("holdrst_m_valid", m_valid, 0);
        check("holdrst_m_err", m_err, 0);
        check("holdrst_result_cnt", result_cnt, 0);
        ready_force = 1'b1;
        release_reset();
        repeat (4) @(negedge clk);
        check("holdrst_no_result", result_cnt, 0);

        // Random regression with gaps on both sides
        rand_ready = 1'b1;
        gaps       = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            for (int k = 0; k < FEAT_CNT; k++) nib[k] = FEAT_BITS'($urandom_range(0, 15));
            send_vector(nib, FEAT_CNT, 1'b1, 1'b1);
        end
        drain("regress_drain");
        check("regress_result_cnt", result_cnt, 1000);
        check("regress_consumed", exp_cnt, 1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
